mc_core: RTL and testbench
==========================

Name: mc_core

Overview:
- Parametrised multi-cycle RV32I integer core; successor to the single-cycle core.
- Fetches and accesses data through valid/ready memory ports, so IMEM/DMEM wait states are tolerated.
- Adds byte/halfword loads and stores, configurable reset vector and register count (RV32I/RV32E), and trap/halt reporting.
- Sits between the instruction memory port and the data memory/bus port; one core per hart.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, architectural register count; legal values 32 (RV32I) or 16 (RV32E).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_valid  output  1  fetch request.
- imem_addr  output  32  fetch address, always word aligned.
- imem_ready  input  1  fetch completes when imem_valid&&imem_ready; imem_rdata is sampled in that cycle.
- imem_rdata  input  32  instruction word.
- dmem_valid  output  1  data request.
- dmem_we  output  1  1 = store, 0 = load.
- dmem_be  output  4  byte enables, lane-aligned to addr[1:0].
- dmem_addr  output  32  word-aligned address, addr[1:0] forced to 0.
- dmem_wdata  output  32  store data, replicated into the enabled lanes.
- dmem_ready  input  1  access completes when dmem_valid&&dmem_ready; load data is sampled in that cycle.
- dmem_rdata  input  32  load data word.
- retire  output  1  one-cycle pulse per committed instruction.
- pc_out  output  32  PC of the instruction in flight.
- halted  output  1  sticky; set by ECALL/EBREAK.
- trap  output  1  sticky; set on an exception.
- trap_cause  output  2  0 illegal instruction, 1 misaligned fetch target, 2 misaligned load/store.

Behaviour:
- Reset (async assert, sync release):
  - state=FETCH; PC=RESET_VECTOR.
  - All outputs 0, except pc_out=RESET_VECTOR and imem_addr=RESET_VECTOR.
  - Register file is not reset; x0 always reads 0 and writes to it are discarded.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- FETCH:
  - imem_valid=1 with imem_addr=PC; hold until ready.
  - On handshake, latch IR and go to DECODE.
  - Address and valid stay stable while ready is low.
- DECODE:
  - Read rs1/rs2 and generate the immediate.
  - Illegal opcode/funct, or any register index >= NUM_REGS -> TRAP, cause 0.
  - ECALL/EBREAK -> HALT. FENCE is treated as a NOP.
- EXEC:
  - ALU op: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; shift amount is operand[4:0].
  - Compute the branch condition and targets: JAL/branch PC+imm; JALR (rs1+imm)&~1.
  - Taken branch or jump whose target has bit1 set -> TRAP, cause 1; PC unchanged and rd not written.
  - Load/store: effective address = rs1+imm. Misalignment (half with a[0]=1, word with a[1:0]!=0) -> TRAP, cause 2; otherwise go to MEM.
  - All other instructions go to WB.
- MEM:
  - dmem_valid=1 until ready.
  - SB/SH/SW: be = 0001<<a, 0011<<a, 1111; wdata = byte or half replicated across lanes.
  - Loads extract the lane selected by a[1:0], then sign- or zero-extend (LB/LH/LW/LBU/LHU).
- WB:
  - Write rd: ALU result, load data, PC+4 for JAL/JALR, imm for LUI, PC+imm for AUIPC.
  - Update PC; pulse retire; go to FETCH.
- Latency with zero-wait memories (imem_ready and dmem_ready tied 1):
  - ALU/branch/jump: 4 cycles per instruction.
  - Load/store: 5 cycles.
  - Each stalled ready cycle adds 1.
- Arithmetic wraps modulo 2^32, with no overflow detection. PC+4 wraps from 0xFFFF_FFFC to 0.
- HALT/TRAP:
  - Terminal until reset; no further memory requests.
  - halted/trap held at 1; pc_out holds the faulting/halting PC.
  - Trapping or halting instructions do not retire.
- Reset asserted mid-handshake: requests drop immediately (asynchronously); the in-flight transaction is abandoned and must not be completed later.

Test Plan:
- ADDI x1,x0,5; ADDI x2,x1,-7; SUB x3,x1,x2 with zero wait -> x3=7; retire every 4th cycle; PC=0,4,8,12.
- SW of 0xDEADBEEF to 0x100, then LB/LBU from 0x103 -> be=1111 on the store; load be=1000; x=0xFFFFFFDE, then 0x000000DE.
- BEQ taken to +8, BNE not taken, JAL to +16 -> PCs follow targets; JAL rd = PC+4.
- imem_ready low for 3 cycles during a fetch -> imem_addr/imem_valid stable; the ADDI retires on cycle 7.
- LW from 0x102 -> trap=1, trap_cause=2, no dmem_valid, rd unchanged, retire not pulsed. Separately, NUM_REGS=16 with ADD x20 -> trap_cause=0.
- EBREAK -> halted=1, no further imem_valid. rst pulse mid-fetch -> imem_valid drops asynchronously; restart at RESET_VECTOR=0x80.

Source files
------------

// File: rtl/mc_core_if.sv
// Memory-side bus of mc_core: valid/ready instruction fetch port and data port.
// The core is the master on both ports.
interface mc_core_if;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        dmem_valid;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output imem_valid, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  imem_valid, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_valid, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mc_core.sv
// Multi-cycle RV32I/RV32E core: FETCH -> DECODE -> EXEC -> (MEM) -> WB, with
// valid/ready memory ports and sticky halt/trap reporting.
module mc_core #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          NUM_REGS     = 32
) (
    input  logic        clk,
    input  logic        rst,
    mc_core_if.master   bus,
    output logic        retire,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause
);
    localparam bit RV32E = (NUM_REGS == 16);
    localparam int AW    = RV32E ? 4 : 5;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d;
    logic [31:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [31:0] res_q, res_d, npc_q, npc_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  lo_q, lo_d, cause_q, cause_d;
    logic        we_q, we_d;

    logic [31:0] rf [NUM_REGS];
    logic        rf_we;

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;

    assign opcode  = ir_q[6:0];
    assign rd_idx  = ir_q[11:7];
    assign f3      = ir_q[14:12];
    assign rs1_idx = ir_q[19:15];
    assign rs2_idx = ir_q[24:20];
    assign f7      = ir_q[31:25];

    // Instruction legality and which register fields are actually used
    logic legal, use_rs1, use_rs2, use_rd, is_halt, bad_reg;
    always_comb begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        is_halt = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                legal  = 1'b1;
                use_rd = 1'b1;
            end
            OP_JALR: begin
                legal   = (f3 == 3'b000);
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OP_BR: begin
                legal   = (f3 != 3'b010) && (f3 != 3'b011);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LOAD: begin
                legal   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                          (f3 == 3'b100) || (f3 == 3'b101);
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OP_STORE: begin
                legal   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_IMM: begin
                if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else                   legal = 1'b1;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OP_REG: begin
                legal   = (f7 == 7'b0000000) ||
                          ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            OP_FENCE: legal = (f3 == 3'b000);
            OP_SYS: begin
                if ((ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073)) begin
                    legal   = 1'b1;
                    is_halt = 1'b1;
                end
            end
            default: legal = 1'b0;
        endcase
        bad_reg = RV32E && ((use_rs1 && rs1_idx[4]) || (use_rs2 && rs2_idx[4]) ||
                            (use_rd && rd_idx[4]));
    end

    logic [31:0] imm, rs1_val, rs2_val;
    always_comb begin
        case (opcode)
            OP_LUI, OP_AUIPC: imm = {ir_q[31:12], 12'b0};
            OP_JAL:   imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            OP_BR:    imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            OP_STORE: imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            default:  imm = {{20{ir_q[31]}}, ir_q[31:20]};
        endcase
        rs1_val = (rs1_idx == 5'd0) ? 32'd0 : rf[rs1_idx[AW-1:0]];
        rs2_val = (rs2_idx == 5'd0) ? 32'd0 : rf[rs2_idx[AW-1:0]];
    end

    logic [31:0] b_op, alu_y, pc_plus4, tgt, ea, lane, load_val;
    logic [4:0]  shamt;
    logic        br_taken, is_ctl, misaligned;
    always_comb begin
        b_op  = (opcode == OP_REG) ? b_q : imm_q;
        shamt = b_op[4:0];
        case (f3)
            3'b000:  alu_y = ((opcode == OP_REG) && ir_q[30]) ? a_q - b_op : a_q + b_op;
            3'b001:  alu_y = a_q << shamt;
            3'b010:  alu_y = {31'b0, $signed(a_q) < $signed(b_op)};
            3'b011:  alu_y = {31'b0, a_q < b_op};
            3'b100:  alu_y = a_q ^ b_op;
            3'b101:  alu_y = ir_q[30] ? 32'($signed(a_q) >>> shamt) : a_q >> shamt;
            3'b110:  alu_y = a_q | b_op;
            default: alu_y = a_q & b_op;
        endcase
        case (f3)
            3'b000:  br_taken = (a_q == b_q);
            3'b001:  br_taken = (a_q != b_q);
            3'b100:  br_taken = $signed(a_q) < $signed(b_q);
            3'b101:  br_taken = $signed(a_q) >= $signed(b_q);
            3'b110:  br_taken = a_q < b_q;
            3'b111:  br_taken = a_q >= b_q;
            default: br_taken = 1'b0;
        endcase
        pc_plus4 = pc_q + 32'd4;
        tgt      = (opcode == OP_JALR) ? ((a_q + imm_q) & ~32'd1) : pc_q + imm_q;
        is_ctl   = (opcode == OP_JAL) || (opcode == OP_JALR) || ((opcode == OP_BR) && br_taken);
        ea       = a_q + imm_q;
        misaligned = ((f3[1:0] == 2'b01) && ea[0]) || ((f3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
        lane     = bus.dmem_rdata >> {lo_q, 3'b000};
        case (f3)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'b0, lane[7:0]};
            3'b101:  load_val = {16'b0, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        res_d   = res_q;
        npc_d   = npc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        lo_d    = lo_q;
        we_d    = we_q;
        cause_d = cause_q;
        rf_we   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rs1_val;
                b_d   = rs2_val;
                imm_d = imm;
                if (!legal || bad_reg) begin
                    state_d = S_TRAP;
                    cause_d = 2'd0;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                npc_d   = pc_plus4;
                res_d   = alu_y;
                state_d = S_WB;
                case (opcode)
                    OP_LUI:          res_d = imm_q;
                    OP_AUIPC:        res_d = pc_q + imm_q;
                    OP_JAL, OP_JALR: begin
                        res_d = pc_plus4;
                        npc_d = tgt;
                    end
                    OP_BR:           if (br_taken) npc_d = tgt;
                    OP_LOAD, OP_STORE: begin
                        addr_d = {ea[31:2], 2'b00};
                        lo_d   = ea[1:0];
                        we_d   = (opcode == OP_STORE);
                        case (f3[1:0])
                            2'b00: begin
                                be_d    = 4'b0001 << ea[1:0];
                                wdata_d = {4{b_q[7:0]}};
                            end
                            2'b01: begin
                                be_d    = 4'b0011 << ea[1:0];
                                wdata_d = {2{b_q[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = b_q;
                            end
                        endcase
                        if (misaligned) begin
                            state_d = S_TRAP;
                            cause_d = 2'd2;
                        end else begin
                            state_d = S_MEM;
                        end
                    end
                    default: ;
                endcase
                // Trapping jumps leave PC and rd untouched: WB is never reached
                if (is_ctl && tgt[1]) begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    if (!we_q) res_d = load_val;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we   = use_rd && (rd_idx != 5'd0);
                pc_d    = npc_q;
                state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            res_q   <= '0;
            npc_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            res_q   <= res_d;
            npc_q   <= npc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            cause_q <= cause_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we) rf[rd_idx[AW-1:0]] <= res_q;
    end

    // Fetch request is gated by rst so it drops the moment reset asserts
    assign bus.imem_valid = (state_q == S_FETCH) && !rst;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_valid = (state_q == S_MEM);
    assign bus.dmem_we    = we_q;
    assign bus.dmem_be    = be_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;

    assign retire     = (state_q == S_WB);
    assign pc_out     = pc_q;
    assign halted     = (state_q == S_HALT);
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: ALU, byte loads/stores, branches, fetch stall,
// misaligned-load trap, halt, RV32E register trap and mid-fetch reset.
module tb_mc_core;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    always #5 clk = ~clk;

    mc_core_if bus0();
    mc_core_if bus1();

    logic        retire0, halted0, trap0, retire1, halted1, trap1;
    logic [31:0] pc0, pc1;
    logic [1:0]  cause0, cause1;

    mc_core dut0 (
        .clk(clk), .rst(rst0), .bus(bus0), .retire(retire0), .pc_out(pc0),
        .halted(halted0), .trap(trap0), .trap_cause(cause0)
    );

    mc_core #(.RESET_VECTOR(32'h80), .NUM_REGS(16)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1), .retire(retire1), .pc_out(pc1),
        .halted(halted1), .trap(trap1), .trap_cause(cause1)
    );

    logic [31:0] imem [256];
    logic [31:0] dmem [256];

    assign bus0.imem_rdata = imem[bus0.imem_addr[9:2]];
    assign bus1.imem_rdata = imem[bus1.imem_addr[9:2]];
    assign bus0.dmem_rdata = dmem[bus0.dmem_addr[9:2]];
    assign bus1.dmem_rdata = 32'd0;

    always @(posedge clk) begin
        if (bus0.dmem_valid && bus0.dmem_ready && bus0.dmem_we)
            for (int i = 0; i < 4; i++)
                if (bus0.dmem_be[i]) dmem[bus0.dmem_addr[9:2]][8*i +: 8] <= bus0.dmem_wdata[8*i +: 8];
    end

    int n_chk = 0, n_err = 0;
    int cyc, n_ret, n_acc, n_ival;
    logic [31:0] ret_pc [32];
    int          ret_cyc [32];
    logic        acc_we [32];
    logic [3:0]  acc_be [32];
    logic [31:0] acc_addr [32];
    logic [31:0] acc_data [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle of dut0, observed mid-cycle
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus0.imem_valid) n_ival++;
        if (retire0 && n_ret < 32) begin
            ret_pc[n_ret]  = pc0;
            ret_cyc[n_ret] = cyc;
            n_ret++;
        end
        if (bus0.dmem_valid && bus0.dmem_ready && n_acc < 32) begin
            acc_we[n_acc]   = bus0.dmem_we;
            acc_be[n_acc]   = bus0.dmem_be;
            acc_addr[n_acc] = bus0.dmem_addr;
            acc_data[n_acc] = bus0.dmem_wdata;
            n_acc++;
        end
    endtask

    task automatic run0(input int maxc, output bit done);
        done = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (trap0 || halted0) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    int  snap_ival, snap_acc, snap_ret, n_ret1;
    bit  done;

    initial begin
        bus0.imem_ready = 1'b1;
        bus0.dmem_ready = 1'b1;
        bus1.imem_ready = 1'b0;
        bus1.dmem_ready = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        for (int i = 0; i < 256; i++) dmem[i] = 32'd0;

        // Program 1: ALU, stores, byte loads, branches/jump, misaligned LW
        imem[0]  = enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13);            // ADDI x1,x0,5
        imem[1]  = enc_i(32'hFFFF_FFF9, 5'd1, 3'd0, 5'd2, 7'h13);    // ADDI x2,x1,-7
        imem[2]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);             // SUB x3,x1,x2
        imem[3]  = enc_s(32'h180, 5'd3, 5'd0, 3'd2);                 // SW x3,0x180
        imem[4]  = {20'hDEADC, 5'd5, 7'h37};                         // LUI x5
        imem[5]  = enc_i(32'hFFFF_FEEF, 5'd5, 3'd0, 5'd5, 7'h13);    // ADDI x5,x5,-0x111
        imem[6]  = enc_s(32'h100, 5'd5, 5'd0, 3'd2);                 // SW x5,0x100
        imem[7]  = enc_i(32'h103, 5'd0, 3'd0, 5'd6, 7'h03);          // LB x6,0x103
        imem[8]  = enc_i(32'h103, 5'd0, 3'd4, 5'd7, 7'h03);          // LBU x7,0x103
        imem[9]  = enc_s(32'h184, 5'd6, 5'd0, 3'd2);                 // SW x6,0x184
        imem[10] = enc_s(32'h188, 5'd7, 5'd0, 3'd2);                 // SW x7,0x188
        imem[11] = enc_b(32'd8, 5'd1, 5'd1, 3'd0);                   // BEQ x1,x1,+8
        imem[12] = enc_i(32'd1, 5'd0, 3'd0, 5'd8, 7'h13);            // skipped
        imem[13] = enc_b(32'd8, 5'd1, 5'd1, 3'd1);                   // BNE x1,x1,+8
        imem[14] = enc_j(32'd16, 5'd9);                              // JAL x9,+16
        imem[18] = enc_s(32'h18C, 5'd9, 5'd0, 3'd2);                 // SW x9,0x18C
        imem[19] = enc_s(32'h191, 5'd1, 5'd0, 3'd0);                 // SB x1,0x191
        imem[20] = enc_i(32'h102, 5'd0, 3'd2, 5'd1, 7'h03);          // LW x1,0x102
        imem[32] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd20);            // dut1: ADD x20,x0,x0

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ival", 32'(bus0.imem_valid), 32'd0);
        chk("rst_iaddr", bus0.imem_addr, 32'h0);
        chk("rst_pc", pc0, 32'h0);
        chk("rst_dval", 32'(bus0.dmem_valid), 32'd0);
        chk("rst_flags", {29'd0, retire0, halted0, trap0}, 32'd0);
        chk("rst_rv_iaddr", bus1.imem_addr, 32'h80);
        chk("rst_rv_pc", pc1, 32'h80);

        // dut1: reset pulse in the middle of a stalled fetch, then RV32E trap
        @(posedge clk); #1 rst1 = 1'b0;
        @(negedge clk);
        chk("d1_fetch_ival", 32'(bus1.imem_valid), 32'd1);
        chk("d1_fetch_iaddr", bus1.imem_addr, 32'h80);
        #1 rst1 = 1'b1;
        #1 chk("d1_async_drop", 32'(bus1.imem_valid), 32'd0);
        bus1.imem_ready = 1'b1;
        @(posedge clk); #1 rst1 = 1'b0;
        n_ret1 = 0;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (retire1) n_ret1++;
            if (trap1) begin
                done = 1'b1;
                break;
            end
        end
        chk("d1_trap_seen", 32'(done), 32'd1);
        chk("d1_cause", 32'(cause1), 32'd0);
        chk("d1_pc", pc1, 32'h80);
        chk("d1_no_retire", n_ret1, 32'd0);

        // dut0 program 1
        cyc = 0; n_ret = 0; n_acc = 0; n_ival = 0;
        @(posedge clk); #1 rst0 = 1'b0;
        run0(200, done);
        chk("p1_end", 32'(done), 32'd1);
        chk("p1_nret", n_ret, 32'd16);
        chk("p1_pc0", ret_pc[0], 32'h0);
        chk("p1_pc1", ret_pc[1], 32'h4);
        chk("p1_pc2", ret_pc[2], 32'h8);
        chk("p1_cyc0", ret_cyc[0], 32'd4);
        chk("p1_cyc1", ret_cyc[1], 32'd8);
        chk("p1_cyc2", ret_cyc[2], 32'd12);
        chk("p1_cyc_lb", ret_cyc[7], 32'd35);
        chk("p1_pc_bne", ret_pc[12], 32'h34);
        chk("p1_pc_jal", ret_pc[13], 32'h38);
        chk("p1_pc_jtgt", ret_pc[14], 32'h48);
        chk("p1_pc_sb", ret_pc[15], 32'h4C);
        chk("p1_nacc", n_acc, 32'd8);
        chk("sub_x3", acc_data[0], 32'd7);
        chk("sw_addr", acc_addr[1], 32'h100);
        chk("sw_be", 32'(acc_be[1]), 32'hF);
        chk("sw_data", acc_data[1], 32'hDEADBEEF);
        chk("lb_we", 32'(acc_we[2]), 32'd0);
        chk("lb_be", 32'(acc_be[2]), 32'h8);
        chk("lb_addr", acc_addr[2], 32'h100);
        chk("lbu_be", 32'(acc_be[3]), 32'h8);
        chk("lb_val", acc_data[4], 32'hFFFFFFDE);
        chk("lbu_val", acc_data[5], 32'h000000DE);
        chk("jal_link", acc_data[6], 32'h3C);
        chk("sb_addr", acc_addr[7], 32'h190);
        chk("sb_be", 32'(acc_be[7]), 32'h2);
        chk("sb_data", acc_data[7], 32'h05050505);
        chk("lw_trap", 32'(trap0), 32'd1);
        chk("lw_cause", 32'(cause0), 32'd2);
        chk("lw_pc", pc0, 32'h50);
        chk("lw_not_halt", 32'(halted0), 32'd0);
        snap_ival = n_ival; snap_acc = n_acc; snap_ret = n_ret;
        repeat (5) step();
        chk("trap_no_fetch", n_ival, snap_ival);
        chk("trap_no_dmem", n_acc, snap_acc);
        chk("trap_no_retire", n_ret, snap_ret);

        // dut0 program 2: stalled fetch, x1 survives the trapped LW, EBREAK
        @(negedge clk); #1 rst0 = 1'b1;
        #1 chk("rst_clears_trap", 32'(trap0), 32'd0);
        imem[0] = enc_i(32'd9, 5'd0, 3'd0, 5'd2, 7'h13);             // ADDI x2,x0,9
        imem[1] = enc_s(32'h180, 5'd1, 5'd0, 3'd2);                  // SW x1,0x180
        imem[2] = enc_s(32'h184, 5'd2, 5'd0, 3'd2);                  // SW x2,0x184
        imem[3] = 32'h0010_0073;                                     // EBREAK
        bus0.imem_ready = 1'b0;
        cyc = 0; n_ret = 0; n_acc = 0; n_ival = 0;
        @(posedge clk); #1 rst0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ival", 32'(bus0.imem_valid), 32'd1);
            chk("stall_iaddr", bus0.imem_addr, 32'h0);
        end
        @(posedge clk); #1 bus0.imem_ready = 1'b1;
        run0(100, done);
        chk("p2_end", 32'(done), 32'd1);
        chk("stall_ret_cyc", ret_cyc[0], 32'd7);
        chk("stall_ret_pc", ret_pc[0], 32'h0);
        chk("x1_unchanged", acc_data[0], 32'd5);
        chk("x2_val", acc_data[1], 32'd9);
        chk("halt_flag", 32'(halted0), 32'd1);
        chk("halt_no_trap", 32'(trap0), 32'd0);
        chk("halt_pc", pc0, 32'h0C);
        chk("halt_nret", n_ret, 32'd3);
        snap_ival = n_ival;
        repeat (5) step();
        chk("halt_no_fetch", n_ival, snap_ival);
        chk("halt_held", 32'(halted0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
